// File: rtl/mem_access_unit.sv
// Load/store stage: checks alignment, issues one 64-bit bus transaction per access,
// lane-shifts store data and extracts/extends load data, reports RISC-V fault causes.
module mem_access_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            bus_req_valid,
    input  logic            bus_req_ready,
    output logic [XLEN-1:0] bus_addr,
    output logic            bus_we,
    output logic [7:0]      bus_wstrb,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_rsp_valid,
    input  logic            bus_rsp_error,
    input  logic [XLEN-1:0] bus_rdata,
    output logic            done_valid,
    input  logic            done_ready,
    output logic [XLEN-1:0] done_data,
    output logic            done_fault,
    output logic [3:0]      done_cause,
    output logic [XLEN-1:0] done_tval
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic            r_is_store;
    logic [1:0]      r_size;
    logic            r_unsigned;
    logic [XLEN-1:0] r_addr;

    logic [XLEN-1:0] r_bus_addr;
    logic            r_bus_we;
    logic [7:0]      r_bus_wstrb;
    logic [XLEN-1:0] r_bus_wdata;

    logic            r_done_valid;
    logic [XLEN-1:0] r_done_data;
    logic            r_done_fault;
    logic [3:0]      r_done_cause;
    logic [XLEN-1:0] r_done_tval;

    logic            w_misaligned;
    logic [7:0]      w_size_strb;
    logic [XLEN-1:0] w_wdata_rep;
    logic [5:0]      w_req_shift;
    logic [5:0]      w_rsp_shift;
    logic [7:0]      w_wstrb;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_rdata_shifted;
    logic [XLEN-1:0] w_load_data;

    assign w_req_shift     = {req_addr[2:0], 3'b000};
    assign w_rsp_shift     = {r_addr[2:0], 3'b000};
    assign w_wstrb         = w_size_strb << req_addr[2:0];
    assign w_wdata         = w_wdata_rep << w_req_shift;
    assign w_rdata_shifted = bus_rdata >> w_rsp_shift;

    // Store data is replicated across lanes first so the shift lands it on the addressed bytes.
    always_comb begin
        w_misaligned = 1'b0;
        w_size_strb  = 8'h00;
        w_wdata_rep  = '0;
        case (req_size)
            2'd0: begin
                w_misaligned = 1'b0;
                w_size_strb  = 8'h01;
                w_wdata_rep  = {(XLEN/8){req_wdata[7:0]}};
            end
            2'd1: begin
                w_misaligned = req_addr[0];
                w_size_strb  = 8'h03;
                w_wdata_rep  = {(XLEN/16){req_wdata[15:0]}};
            end
            2'd2: begin
                w_misaligned = |req_addr[1:0];
                w_size_strb  = 8'h0F;
                w_wdata_rep  = {(XLEN/32){req_wdata[31:0]}};
            end
            default: begin
                w_misaligned = |req_addr[2:0];
                w_size_strb  = 8'hFF;
                w_wdata_rep  = req_wdata;
            end
        endcase
    end

    always_comb begin
        w_load_data = '0;
        case (r_size)
            2'd0: w_load_data = r_unsigned ? {{(XLEN-8){1'b0}}, w_rdata_shifted[7:0]}
                                           : {{(XLEN-8){w_rdata_shifted[7]}}, w_rdata_shifted[7:0]};
            2'd1: w_load_data = r_unsigned ? {{(XLEN-16){1'b0}}, w_rdata_shifted[15:0]}
                                           : {{(XLEN-16){w_rdata_shifted[15]}}, w_rdata_shifted[15:0]};
            2'd2: w_load_data = r_unsigned ? {{(XLEN-32){1'b0}}, w_rdata_shifted[31:0]}
                                           : {{(XLEN-32){w_rdata_shifted[31]}}, w_rdata_shifted[31:0]};
            default: w_load_data = w_rdata_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        req_ready     = 1'b0;
        bus_req_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = w_misaligned ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                bus_req_valid = 1'b1;
                if (bus_req_ready) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_rsp_valid) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (done_ready) begin
                    w_next_state = S_IDLE;
                end
            end
        endcase
    end

    // Responses arriving in REQ or DONE are ignored because only the WAIT arm samples them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_is_store   <= 1'b0;
            r_size       <= 2'd0;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_bus_addr   <= '0;
            r_bus_we     <= 1'b0;
            r_bus_wstrb  <= 8'h00;
            r_bus_wdata  <= '0;
            r_done_valid <= 1'b0;
            r_done_data  <= '0;
            r_done_fault <= 1'b0;
            r_done_cause <= 4'd0;
            r_done_tval  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_is_store <= req_is_store;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        if (w_misaligned) begin
                            r_done_valid <= 1'b1;
                            r_done_data  <= '0;
                            r_done_fault <= 1'b1;
                            r_done_cause <= req_is_store ? 4'd6 : 4'd4;
                            r_done_tval  <= req_addr;
                        end else begin
                            r_bus_addr  <= {req_addr[XLEN-1:3], 3'b000};
                            r_bus_we    <= req_is_store;
                            r_bus_wstrb <= req_is_store ? w_wstrb : 8'h00;
                            r_bus_wdata <= req_is_store ? w_wdata : '0;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_req_ready) begin
                        r_bus_addr  <= '0;
                        r_bus_we    <= 1'b0;
                        r_bus_wstrb <= 8'h00;
                        r_bus_wdata <= '0;
                    end
                end
                S_WAIT: begin
                    if (bus_rsp_valid) begin
                        r_done_valid <= 1'b1;
                        if (bus_rsp_error) begin
                            r_done_data  <= '0;
                            r_done_fault <= 1'b1;
                            r_done_cause <= r_is_store ? 4'd7 : 4'd5;
                            r_done_tval  <= r_addr;
                        end else begin
                            r_done_data  <= r_is_store ? '0 : w_load_data;
                            r_done_fault <= 1'b0;
                            r_done_cause <= 4'd0;
                            r_done_tval  <= '0;
                        end
                    end
                end
                S_DONE: begin
                    if (done_ready) begin
                        r_done_valid <= 1'b0;
                        r_done_data  <= '0;
                        r_done_fault <= 1'b0;
                        r_done_cause <= 4'd0;
                        r_done_tval  <= '0;
                    end
                end
            endcase
        end
    end

    assign bus_addr   = r_bus_addr;
    assign bus_we     = r_bus_we;
    assign bus_wstrb  = r_bus_wstrb;
    assign bus_wdata  = r_bus_wdata;
    assign done_valid = r_done_valid;
    assign done_data  = r_done_data;
    assign done_fault = r_done_fault;
    assign done_cause = r_done_cause;
    assign done_tval  = r_done_tval;

endmodule
